// File: rtl/ccr_branch_unit_if.sv
// Bus between the execute stage and the CCR/branch unit.
// The master drives flags and branch requests; the slave returns CCR and fetch-redirect controls.
interface ccr_branch_unit_if;
  logic [2:0]  alu_flag;
  logic        flag_we;
  logic        setc;
  logic        clrc;
  logic        br_valid;
  logic [1:0]  br_type;
  logic [15:0] br_target;
  logic        int_save;
  logic        rti_restore;
  logic [2:0]  ccr;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        flush;

  modport master (
    output alu_flag, flag_we, setc, clrc, br_valid, br_type, br_target,
           int_save, rti_restore,
    input  ccr, pc_load, pc_target, flush
  );

  modport slave (
    input  alu_flag, flag_we, setc, clrc, br_valid, br_type, br_target,
           int_save, rti_restore,
    output ccr, pc_load, pc_target, flush
  );
endinterface

// File: rtl/ccr_branch_unit.sv
// Condition code register with interrupt shadow, plus a three-state branch
// sequencer that issues a one-cycle PC load followed by a two-cycle flush.
module ccr_branch_unit (
  input  logic               clk,
  input  logic               rst,
  ccr_branch_unit_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  localparam logic [1:0] BR_JMP = 2'b00;
  localparam logic [1:0] BR_JZ  = 2'b01;
  localparam logic [1:0] BR_JN  = 2'b10;
  localparam logic [1:0] BR_JC  = 2'b11;

  logic [1:0]  state_q,     state_d;
  logic [2:0]  ccr_q,       ccr_d;
  logic [2:0]  shadow_q,    shadow_d;
  logic [15:0] pc_target_q, pc_target_d;
  logic        pc_load_q,   pc_load_d;
  logic        flush_q,     flush_d;

  logic        cond_s;
  logic        taken_s;
  logic        clr_z_s;
  logic        clr_c_s;
  logic        clr_n_s;

  // Condition is evaluated on the registered CCR only, never on a same-cycle flag write.
  always_comb begin
    cond_s = 1'b0;
    case (bus.br_type)
      BR_JMP:  cond_s = 1'b1;
      BR_JZ:   cond_s = ccr_q[0];
      BR_JN:   cond_s = ccr_q[2];
      BR_JC:   cond_s = ccr_q[1];
      default: cond_s = 1'b0;
    endcase
  end

  assign taken_s = bus.br_valid & (state_q == ST_IDLE) & cond_s;
  assign clr_z_s = taken_s & (bus.br_type == BR_JZ);
  assign clr_c_s = taken_s & (bus.br_type == BR_JC);
  assign clr_n_s = taken_s & (bus.br_type == BR_JN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (taken_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD:  state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign pc_load_d = (state_d == ST_LOAD);
  assign flush_d   = (state_d == ST_LOAD) | (state_d == ST_FLUSH);

  always_comb begin
    pc_target_d = pc_target_q;
    if (taken_s) begin
      pc_target_d = bus.br_target;
    end else begin
      pc_target_d = pc_target_q;
    end
  end

  // Per-bit priority: restore, then flag write, then set/clear C, then branch clear.
  always_comb begin
    ccr_d = ccr_q;
    if (bus.rti_restore) begin
      ccr_d = shadow_q;
    end else if (bus.flag_we) begin
      ccr_d = bus.alu_flag;
    end else begin
      ccr_d[0] = clr_z_s ? 1'b0 : ccr_q[0];
      ccr_d[2] = clr_n_s ? 1'b0 : ccr_q[2];
      if (bus.setc & ~bus.clrc) begin
        ccr_d[1] = 1'b1;
      end else if (bus.clrc & ~bus.setc) begin
        ccr_d[1] = 1'b0;
      end else if (bus.setc & bus.clrc) begin
        ccr_d[1] = ccr_q[1];
      end else begin
        ccr_d[1] = clr_c_s ? 1'b0 : ccr_q[1];
      end
    end
  end

  // Shadow samples the pre-edge CCR, so save+restore together swaps the two.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.int_save) begin
      shadow_d = ccr_q;
    end else begin
      shadow_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ccr_q       <= 3'b000;
      shadow_q    <= 3'b000;
      pc_target_q <= 16'h0000;
      pc_load_q   <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ccr_q       <= ccr_d;
      shadow_q    <= shadow_d;
      pc_target_q <= pc_target_d;
      pc_load_q   <= pc_load_d;
      flush_q     <= flush_d;
    end
  end

  assign bus.ccr       = ccr_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.pc_target = pc_target_q;
  assign bus.flush     = flush_q;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Table-driven bench for ccr_branch_unit with a scoreboard of expected post-edge outputs.
module tb_ccr_branch_unit;

  logic clk;
  logic rst;
  ccr_branch_unit_if bus ();

  ccr_branch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fwe;
    logic [2:0]  alu;
    logic        setc;
    logic        clrc;
    logic        bv;
    logic [1:0]  bt;
    logic [15:0] tgt;
    logic        isv;
    logic        rti;
    logic [2:0]  e_ccr;
    logic        e_pl;
    logic        e_fl;
    logic [15:0] e_tgt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  ccr;
    logic        pl;
    logic        fl;
    logic [15:0] tgt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pulses;

  task automatic add(input logic r, input logic fwe, input logic [2:0] alu,
                     input logic sc, input logic cc, input logic bv,
                     input logic [1:0] bt, input logic [15:0] tgt,
                     input logic isv, input logic rti,
                     input logic [2:0] e_ccr, input logic e_pl,
                     input logic e_fl, input logic [15:0] e_tgt);
    vec_t v;
    v.rst = r; v.fwe = fwe; v.alu = alu; v.setc = sc; v.clrc = cc;
    v.bv = bv; v.bt = bt; v.tgt = tgt; v.isv = isv; v.rti = rti;
    v.e_ccr = e_ccr; v.e_pl = e_pl; v.e_fl = e_fl; v.e_tgt = e_tgt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, push its expectation, then compare after the edge.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst             = v.rst;
    bus.flag_we     = v.fwe;
    bus.alu_flag    = v.alu;
    bus.setc        = v.setc;
    bus.clrc        = v.clrc;
    bus.br_valid    = v.bv;
    bus.br_type     = v.bt;
    bus.br_target   = v.tgt;
    bus.int_save    = v.isv;
    bus.rti_restore = v.rti;
    e.idx = idx; e.ccr = v.e_ccr; e.pl = v.e_pl; e.fl = v.e_fl; e.tgt = v.e_tgt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("ccr",       g.idx, {13'd0, bus.ccr},     {13'd0, g.ccr});
    chk("pc_load",   g.idx, {15'd0, bus.pc_load}, {15'd0, g.pl});
    chk("flush",     g.idx, {15'd0, bus.flush},   {15'd0, g.fl});
    chk("pc_target", g.idx, bus.pc_target,        g.tgt);
    if (bus.pc_load === 1'b1) pulses++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [2:0] a;
    rst = 1'b1;
    bus.flag_we = 1'b0; bus.alu_flag = 3'b000; bus.setc = 1'b0; bus.clrc = 1'b0;
    bus.br_valid = 1'b0; bus.br_type = 2'b00; bus.br_target = 16'h0000;
    bus.int_save = 1'b0; bus.rti_restore = 1'b0;
    pulses = 0;

    //   rst  fwe  alu     sc   cc   bv   bt     tgt       isv  rti  ccr     pl   fl   tgt
    add(1'b1,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0000);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0000);
    // flag write then JZ taken, Z cleared
    add(1'b0,1'b1,3'b011,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b011,1'b0,1'b0,16'h0000);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b01,16'h0040,1'b0,1'b0,3'b010,1'b1,1'b1,16'h0040);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b010,1'b0,1'b1,16'h0040);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b010,1'b0,1'b0,16'h0040);
    // JC not taken, then setc and JC taken
    add(1'b0,1'b1,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0040);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b11,16'h9999,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0040);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0040);
    add(1'b0,1'b0,3'b000,1'b1,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b010,1'b0,1'b0,16'h0040);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b11,16'h0100,1'b0,1'b0,3'b000,1'b1,1'b1,16'h0100);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b1,16'h0100);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0100);
    // JMP taken, second JMP in LOAD and FLUSH ignored
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b00,16'h1234,1'b0,1'b0,3'b000,1'b1,1'b1,16'h1234);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b00,16'h5555,1'b0,1'b0,3'b000,1'b0,1'b1,16'h1234);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b00,16'h5555,1'b0,1'b0,3'b000,1'b0,1'b0,16'h1234);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h1234);
    // save / restore / swap
    add(1'b0,1'b1,3'b101,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b101,1'b0,1'b0,16'h1234);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b1,1'b0,3'b101,1'b0,1'b0,16'h1234);
    add(1'b0,1'b1,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h1234);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b1,3'b101,1'b0,1'b0,16'h1234);
    add(1'b0,1'b1,3'b010,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b010,1'b0,1'b0,16'h1234);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b1,1'b1,3'b101,1'b0,1'b0,16'h1234);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b1,3'b010,1'b0,1'b0,16'h1234);
    // reset during LOAD abandons the branch
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b00,16'hABCD,1'b0,1'b0,3'b010,1'b1,1'b1,16'hABCD);
    add(1'b1,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0000);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0000);
    // JN taken while flag_we rewrites N=1: flag write wins
    add(1'b0,1'b1,3'b100,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b100,1'b0,1'b0,16'h0000);
    add(1'b0,1'b1,3'b100,1'b0,1'b0,1'b1,2'b10,16'h0200,1'b0,1'b0,3'b100,1'b1,1'b1,16'h0200);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b100,1'b0,1'b1,16'h0200);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b100,1'b0,1'b0,16'h0200);
    // no bypass: same-cycle Z write does not make JZ taken
    add(1'b0,1'b1,3'b001,1'b0,1'b0,1'b1,2'b01,16'h0300,1'b0,1'b0,3'b001,1'b0,1'b0,16'h0200);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b01,16'h0300,1'b0,1'b0,3'b000,1'b1,1'b1,16'h0300);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b1,16'h0300);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0300);
    // setc/clrc combinations
    add(1'b0,1'b0,3'b000,1'b1,1'b1,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0300);
    add(1'b0,1'b0,3'b000,1'b1,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b010,1'b0,1'b0,16'h0300);
    add(1'b0,1'b0,3'b000,1'b1,1'b1,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b010,1'b0,1'b0,16'h0300);
    add(1'b0,1'b0,3'b000,1'b0,1'b1,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b000,1'b0,1'b0,16'h0300);
    // flag write honoured in LOAD, JZ in FLUSH ignored (no clear)
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b00,16'h0001,1'b0,1'b0,3'b000,1'b1,1'b1,16'h0001);
    add(1'b0,1'b1,3'b111,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b111,1'b0,1'b1,16'h0001);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,2'b01,16'h0bad,1'b0,1'b0,3'b111,1'b0,1'b0,16'h0001);
    add(1'b0,1'b0,3'b000,1'b0,1'b0,1'b0,2'b00,16'h0000,1'b0,1'b0,3'b111,1'b0,1'b0,16'h0001);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // JMP held valid for six edges: a pulse every third cycle
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      v = '{rst:1'b0, fwe:1'b0, alu:3'b000, setc:1'b0, clrc:1'b0, bv:1'b1,
            bt:2'b00, tgt:16'h7777, isv:1'b0, rti:1'b0, e_ccr:3'b111,
            e_pl:((i % 3) == 0), e_fl:((i % 3) != 2), e_tgt:16'h7777};
      apply(100 + i, v);
    end
    chk("pulse_count", 106, 16'(pulses), 16'd2);

    // reset then a burst of random flag writes
    v = '{rst:1'b1, fwe:1'b0, alu:3'b000, setc:1'b0, clrc:1'b0, bv:1'b0,
          bt:2'b00, tgt:16'h0000, isv:1'b0, rti:1'b0, e_ccr:3'b000,
          e_pl:1'b0, e_fl:1'b0, e_tgt:16'h0000};
    apply(200, v);
    for (int i = 0; i < 8; i++) begin
      a = 3'($urandom_range(7, 0));
      v = '{rst:1'b0, fwe:1'b1, alu:a, setc:1'b0, clrc:1'b0, bv:1'b0,
            bt:2'b00, tgt:16'h0000, isv:1'b0, rti:1'b0, e_ccr:a,
            e_pl:1'b0, e_fl:1'b0, e_tgt:16'h0000};
      apply(201 + i, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ccr_branch_unit.md
CCR_BRANCH_UNIT -- requirements
Module: ccr_branch_unit

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 alu_flag  input  3  ALU flags from EX: bit0 Z (zero), bit1 C (carry), bit2 N (negative).
REQ-004 flag_we  input  1  latch alu_flag into CCR this cycle.
REQ-005 setc / clrc  input  1 each  force C to 1 / to 0.
REQ-006 br_valid  input  1  branch instruction present in EX.
REQ-007 br_type  input  2  00 JMP (unconditional), 01 JZ, 10 JN, 11 JC.
REQ-008 br_target  input  16  branch destination address.
REQ-009 int_save  input  1  copy CCR into shadow register (interrupt entry).
REQ-010 rti_restore  input  1  copy shadow register into CCR (return from interrupt).
REQ-011 ccr  output  3  current condition code register, same bit order as alu_flag.
REQ-012 pc_load  output  1  one-cycle pulse: fetch stage loads pc_target.
REQ-013 pc_target  output  16  registered branch destination.
REQ-014 flush  output  1  squash IF/ID contents while high.

Function
REQ-015 The CCR SHALL update only when flag_we, setc, clrc, rti_restore, or a taken conditional branch occurs; otherwise it holds.
REQ-016 Per-bit CCR precedence, highest first: rst > rti_restore > flag_we > setc/clrc > branch flag-clear.
REQ-017 setc and clrc both high SHALL leave C unchanged.
REQ-018 Branch condition SHALL use the registered ccr value at the sampling edge (no bypass of a same-cycle flag_we).
REQ-019 Taken = br_valid & state IDLE & (JMP | (JZ & Z) | (JN & N) | (JC & C)).
REQ-020 A taken JZ/JN/JC SHALL clear the tested flag at the same edge, subject to REQ-016; JMP SHALL not modify CCR.
REQ-021 A not-taken branch SHALL produce no pulse, no flush, and no CCR change.
REQ-022 State machine: IDLE -> LOAD on taken; LOAD -> FLUSH unconditionally; FLUSH -> IDLE unconditionally.
REQ-023 LOAD: pc_load=1, flush=1, pc_target = br_target captured at the taken edge.
REQ-024 FLUSH: pc_load=0, flush=1; IDLE: pc_load=0, flush=0.
REQ-025 Latency: taken branch sampled at edge T -> pc_load/flush high in cycle T+1, flush high in T+2, both low from T+3.
REQ-026 br_valid in LOAD or FLUSH SHALL be ignored: no condition evaluation, no flag clear.
REQ-027 pc_target SHALL hold its last captured value outside LOAD.
REQ-028 flag_we, setc, clrc, int_save, rti_restore SHALL be honoured in every state.
REQ-029 int_save and rti_restore in the same cycle SHALL swap: CCR takes the old shadow, shadow takes the old CCR.

Reset
REQ-030 With rst high at an edge: ccr=000, shadow=000, state=IDLE, pc_load=0, flush=0, pc_target=0x0000.
REQ-031 rst SHALL override every other input in that cycle, including a branch in progress, which is abandoned.
REQ-032 Outputs SHALL be defined from the first edge with rst high; no asynchronous path.

Verification
REQ-033 flag_we=1, alu_flag=011 -> ccr=011 next cycle; then JZ br_target=0x0040 -> T+1 pc_load=1, pc_target=0x0040, flush=1; T+2 flush=1; ccr=010.
REQ-034 ccr=000, JC -> no pulse, flush stays 0, ccr stays 000; setc then JC -> taken, ccr=000 afterwards.
REQ-035 JMP 0x1234 taken, second JMP 0x5555 presented in LOAD and FLUSH cycles -> only one pc_load pulse, pc_target stays 0x1234.
REQ-036 ccr=101, int_save, flag_we alu_flag=000, rti_restore -> ccr=101; int_save together with rti_restore -> swap per REQ-029.
REQ-037 rst asserted in the LOAD cycle -> next cycle pc_load=0, flush=0, ccr=000, pc_target=0x0000, state IDLE.
REQ-038 JN taken with flag_we alu_flag=100 in the same cycle -> branch taken, N stays 1 (flag_we wins).
